// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver files.
//   ST_*           FSM state encoding for uart_rx_gen
//   PRESCALE_*     the oversampling ratios the receiver supports
//   presc_t        width that holds any supported ratio (up to 32)
//   norm_prescale  maps a raw ratio to a supported one; anything unsupported becomes 8
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  typedef logic [5:0] presc_t;

  function automatic presc_t norm_prescale(input logic [31:0] raw);
    if (raw == 32'(PRESCALE_16)) return presc_t'(PRESCALE_16);
    if (raw == 32'(PRESCALE_32)) return presc_t'(PRESCALE_32);
    return presc_t'(PRESCALE_8);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit timing for the UART receiver.
//   clk, rst_b  clock, synchronous active-low reset
//   run         high while a frame is in progress; the edge counter is held at 0 otherwise
//   rx          serial line
//   presc       latched oversampling ratio P
//   bit_val     majority of the three samples taken around the bit centre
//   bit_done    high on the last cycle of a bit period (edge counter = P-1)
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic   clk,
  input  logic   rst_b,
  input  logic   run,
  input  logic   rx,
  input  presc_t presc,
  output logic   bit_val,
  output logic   bit_done
);

  presc_t     edge_cnt;
  presc_t     half;
  logic [2:0] samp;

  assign half = presc >> 1;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      edge_cnt <= '0;
      samp     <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
    end else begin
      if (edge_cnt == presc - 6'd1) edge_cnt <= '0;
      else                          edge_cnt <= edge_cnt + 6'd1;
      if (edge_cnt == half - 6'd1) samp[0] <= rx;
      if (edge_cnt == half)        samp[1] <= rx;
      if (edge_cnt == half + 6'd1) samp[2] <= rx;
    end
  end

  // All three samples have been captured well before edge_cnt reaches P-1.
  assign bit_done = run && (edge_cnt == presc - 6'd1);
  assign bit_val  = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

endmodule

// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampling UART receiver with optional parity and one or two stop bits.
//   CLK, RST        clock, synchronous active-low reset
//   RX_IN           serial line, idle high, already synchronous to CLK
//   Prescale        oversampling ratio (8/16/32; anything else runs as 8)
//   PAR_EN/PAR_TYP  parity present / odd parity
//   STOP2           two stop bits
//   P_DATA          last good word, held between DATA_VLD pulses
//   DATA_VLD, parity_error, framing_error  one-cycle pulses at frame evaluation
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low; configuration latched on exit
// ST_START  | start bit; a high majority means a glitch, so go back to idle
// ST_DATA   | DATA_WIDTH data bits, LSB first
// ST_PARITY | parity bit (only when parity is enabled)
// ST_STOP   | one or two stop bits; the frame is evaluated on the last one
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VLD,
  output logic                  parity_error,
  output logic                  framing_error
);

  logic [2:0]            state;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  par_bit;
  logic                  stop_cnt;
  logic                  stop_err;
  presc_t                presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic                  run;
  logic                  bit_val;
  logic                  bit_done;
  logic                  stop_bad;
  logic                  par_bad;

  assign run = (state != ST_IDLE);

  uart_rx_sampler u_sampler (
    .clk      (CLK),
    .rst_b    (RST),
    .run      (run),
    .rx       (RX_IN),
    .presc    (presc_q),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  // stop_err carries a bad first stop bit over to the second one.
  assign stop_bad = stop_err | ~bit_val;
  assign par_bad  = par_en_q & (par_bit != ((^data_sr) ^ par_typ_q));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      data_sr       <= '0;
      par_bit       <= 1'b0;
      stop_cnt      <= 1'b0;
      stop_err      <= 1'b0;
      presc_q       <= presc_t'(PRESCALE_8);
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      stop2_q       <= 1'b0;
      P_DATA        <= '0;
      DATA_VLD      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      DATA_VLD      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!RX_IN) begin
            state     <= ST_START;
            presc_q   <= norm_prescale(32'(Prescale));
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            stop_err  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) state <= bit_val ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (bit_done) begin
            data_sr <= {bit_val, data_sr[DATA_WIDTH-1:1]};
            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            par_bit <= bit_val;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
              stop_err <= stop_bad;
            end else begin
              stop_cnt      <= 1'b0;
              state         <= ST_IDLE;
              parity_error  <= par_bad;
              framing_error <= stop_bad;
              if (!stop_bad && !par_bad) begin
                P_DATA   <= data_sr;
                DATA_VLD <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_gen.sv
// Bench for uart_rx_gen: an 8-bit and a 9-bit instance on separate serial lines.
// Each frame sent is described once (data, ratio, parity, stop bits); the expected
// outcome and its cycle are worked out from the frame rules, queued, and compared
// against both instances on every falling edge.
module tb_uart_rx_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx9 = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [7:0] pd8;
  logic [8:0] pd9;
  logic       vld8, pe8, fe8, vld9, pe9, fe9;

  always #5 CLK = ~CLK;

  uart_rx_gen #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
    .CLK(CLK), .RST(RST), .RX_IN(rx8), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd8), .DATA_VLD(vld8),
    .parity_error(pe8), .framing_error(fe8));

  uart_rx_gen #(.DATA_WIDTH(9), .PRESCALE_W(6)) dut9 (
    .CLK(CLK), .RST(RST), .RX_IN(rx9), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(pd9), .DATA_VLD(vld9),
    .parity_error(pe9), .framing_error(fe9));

  typedef struct {
    int         cyc;
    bit         vld;
    bit         perr;
    bit         ferr;
    logic [8:0] data;
  } ev_t;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  ev_t        q0[$];
  ev_t        q1[$];
  logic [8:0] mdata [2];
  int         n_vld [2];
  int         n_pe [2];
  int         n_fe [2];
  int         last_vld [2];
  int         last_pe [2];
  int         last_fe [2];
  int         vld_log1[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(input int i, input logic [8:0] pd, input logic v, input logic pe,
                     input logic fe);
    ev_t e;
    e = '{cyc: 0, vld: 1'b0, perr: 1'b0, ferr: 1'b0, data: 9'd0};
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) e = q0.pop_front();
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) e = q1.pop_front();
    end
    if (e.vld) mdata[i] = e.data;
    check($sformatf("data_vld[%0d]", i), 32'(v), 32'(e.vld));
    check($sformatf("parity_error[%0d]", i), 32'(pe), 32'(e.perr));
    check($sformatf("framing_error[%0d]", i), 32'(fe), 32'(e.ferr));
    check($sformatf("p_data[%0d]", i), 32'(pd), 32'(mdata[i]));
    if (v === 1'b1) begin
      n_vld[i]++;
      last_vld[i] = cyc;
      if (i == 1) vld_log1.push_back(cyc);
    end
    if (pe === 1'b1) begin n_pe[i]++; last_pe[i] = cyc; end
    if (fe === 1'b1) begin n_fe[i]++; last_fe[i] = cyc; end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      cmp(0, {1'b0, pd8}, vld8, pe8, fe8);
      cmp(1, pd9, vld9, pe9, fe9);
    end
  end

  function automatic int norm_p(input int raw);
    return (raw == 16 || raw == 32) ? raw : 8;
  endfunction

  // Inputs change 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic set_rx(input int i, input logic b);
    if (i == 0) rx8 = b;
    else        rx9 = b;
  endtask

  task automatic do_reset();
    rx8 = 1'b1;
    rx9 = 1'b1;
    RST = 1'b0;
    tick(1);
    q0.delete();
    q1.delete();
    mdata[0] = '0;
    mdata[1] = '0;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_p_data8", 32'(pd8), 32'h0);
    check("rst_p_data9", 32'(pd9), 32'h0);
    check("rst_data_vld8", 32'(vld8), 32'h0);
    check("rst_parity_error8", 32'(pe8), 32'h0);
    check("rst_framing_error8", 32'(fe8), 32'h0);
    @(posedge CLK);
    #2;
  endtask

  // t0 is the cycle count just after the edge that first sees the start bit.
  // A frame of n bits is evaluated n*P cycles later.  abort_at > 0 resets the
  // design that many cycles into the frame instead of finishing it.
  task automatic send_frame(input int i, input logic [8:0] data, input int praw,
                            input bit pen, input bit ptyp, input bit st2,
                            input bit par_auto, input bit par_val,
                            input bit [1:0] stop_vals, input bit scramble,
                            input int abort_at, output int t0);
    int         w;
    int         p;
    int         n;
    bit         exp_par;
    bit         par_line;
    bit         bits[$];
    ev_t        e;
    logic [8:0] d;
    w = (i == 0) ? 8 : 9;
    p = norm_p(praw);
    d = (i == 0) ? {1'b0, data[7:0]} : data;
    exp_par  = (^d) ^ ptyp;
    par_line = par_auto ? exp_par : par_val;
    bits.push_back(1'b0);
    for (int k = 0; k < w; k++) bits.push_back(d[k]);
    if (pen) bits.push_back(par_line);
    bits.push_back(stop_vals[0]);
    if (st2) bits.push_back(stop_vals[1]);
    n = bits.size();
    Prescale = 6'(praw);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    STOP2    = st2;
    t0 = cyc + 1;
    if (abort_at == 0) begin
      e.cyc  = t0 + n * p;
      e.perr = pen && (par_line != exp_par);
      e.ferr = !(stop_vals[0] && (!st2 || stop_vals[1]));
      e.vld  = !e.perr && !e.ferr;
      e.data = d;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    for (int b = 0; b < n; b++) begin
      set_rx(i, bits[b]);
      for (int c = 0; c < p; c++) begin
        if (abort_at > 0 && (b * p + c) == abort_at) begin
          do_reset();
          return;
        end
        tick(1);
        if (scramble && b == 0 && c == 0) begin
          Prescale = (p == 32) ? 6'd16 : 6'd32;
          PAR_EN   = !pen;
          PAR_TYP  = !ptyp;
          STOP2    = !st2;
        end
      end
    end
    set_rx(i, 1'b1);
  endtask

  initial begin
    int t0;
    int ta;
    int tb2;
    int n_before;
    for (int i = 0; i < 2; i++) begin
      mdata[i] = '0;
      n_vld[i] = 0; n_pe[i] = 0; n_fe[i] = 0;
      last_vld[i] = 0; last_pe[i] = 0; last_fe[i] = 0;
    end

    RST = 1'b0;
    tick(3);
    @(negedge CLK);
    check("init_p_data8", 32'(pd8), 32'h0);
    check("init_p_data9", 32'(pd9), 32'h0);
    check("init_data_vld8", 32'(vld8), 32'h0);
    check("init_parity_error8", 32'(pe8), 32'h0);
    check("init_framing_error8", 32'(fe8), 32'h0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    mon_en = 1'b1;
    tick(4);

    // 0x55 at P=8, no parity, one stop; configuration scrambled after the start edge.
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 0, t0);
    tick(5);
    check("f55_latency", last_vld[0] - t0, 80);
    check("f55_data", 32'(pd8), 32'h55);
    check("f55_vld_count", n_vld[0], 1);

    // 0xA3 at P=16, odd parity, parity bit driven 0 (ones count is 4, so 1 is required).
    send_frame(0, 9'h0A3, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, t0);
    tick(5);
    check("a3_perr_latency", last_pe[0] - t0, 176);
    check("a3_perr_count", n_pe[0], 1);
    check("a3_keeps_data", 32'(pd8), 32'h55);
    check("a3_no_vld", n_vld[0], 1);

    // 0x96 at P=16, even parity, correct parity bit.
    send_frame(0, 9'h096, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 0, t0);
    tick(5);
    check("96_latency", last_vld[0] - t0, 176);
    check("96_data", 32'(pd8), 32'h96);

    // 0x5A at P=32, two stop bits, second stop bit low.
    send_frame(0, 9'h05A, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 0, t0);
    tick(5);
    check("5a_ferr_latency", last_fe[0] - t0, 352);
    check("5a_ferr_count", n_fe[0], 1);
    check("5a_keeps_data", 32'(pd8), 32'h96);

    // Unsupported ratio 12 runs as 8.
    send_frame(0, 9'h081, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 0, t0);
    tick(5);
    check("p12_latency", last_vld[0] - t0, 80);
    check("p12_data", 32'(pd8), 32'h81);

    // One-cycle glitch at P=16; the receiver is idle again 16 cycles later and
    // the next frame starts on the very first cycle it could.
    n_before = n_vld[0] + n_pe[0] + n_fe[0];
    Prescale = 6'd16;
    PAR_EN = 1'b0;
    STOP2 = 1'b0;
    rx8 = 1'b0;
    tick(1);
    rx8 = 1'b1;
    tick(16);
    check("glitch_no_pulse", n_vld[0] + n_pe[0] + n_fe[0], n_before);
    send_frame(0, 9'h00F, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 0, t0);
    tick(5);
    check("0f_latency", last_vld[0] - t0, 160);
    check("0f_data", 32'(pd8), 32'h0F);

    // 9-bit words back to back at P=8: 11-bit frames of 88 cycles, plus the one
    // idle cycle between them.
    send_frame(1, 9'h1FF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 0, ta);
    tick(1);
    send_frame(1, 9'h001, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 0, tb2);
    tick(5);
    check("b2b_vld_count", n_vld[1], 2);
    if (vld_log1.size() == 2) begin
      check("b2b_first_latency", vld_log1[0] - ta, 88);
      check("b2b_spacing", vld_log1[1] - vld_log1[0], 89);
    end else begin
      check("b2b_pulse_log", vld_log1.size(), 2);
    end
    check("b2b_data", 32'(pd9), 32'h001);

    // Reset in the middle of the data bits, then a full frame.
    n_before = n_vld[0] + n_pe[0] + n_fe[0];
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 3 * 8 + 3, t0);
    tick(100);
    check("abort_no_pulse", n_vld[0] + n_pe[0] + n_fe[0], n_before);
    check("abort_data_cleared", 32'(pd8), 32'h0);
    send_frame(0, 9'h03C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0, t0);
    tick(5);
    check("3c_latency", last_vld[0] - t0, 192);
    check("3c_data", 32'(pd8), 32'h3C);

    tick(10);
    check("pending8_empty", q0.size(), 0);
    check("pending9_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
